// File: rtl/video_tint_out.sv
// Monochrome luma to tinted RGB output stage with ce_pix-gated sync/blank pipeline.
// Optional scanline dimming is built in when VIDOUT_SCANLINE_EN is defined.
module video_tint_out #(
  parameter int IW   = 8,
  parameter int PIPE = 2
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ce_pix,
  input  logic [IW-1:0] video_in,
  input  logic          hs_in,
  input  logic          vs_in,
  input  logic          hb_in,
  input  logic          vb_in,
  input  logic [2:0]    mode_in,
  input  logic          sl_en,
  output logic [7:0]    r_out,
  output logic [7:0]    g_out,
  output logic [7:0]    b_out,
  output logic          hs_out,
  output logic          vs_out,
  output logic          de_out,
  output logic          ce_out
);

  localparam logic [2:0] MODE_WHITE   = 3'd0;
  localparam logic [2:0] MODE_RED     = 3'd1;
  localparam logic [2:0] MODE_GREEN   = 3'd2;
  localparam logic [2:0] MODE_BLUE    = 3'd3;
  localparam logic [2:0] MODE_AMBER   = 3'd4;
  localparam logic [2:0] MODE_CYAN    = 3'd5;
  localparam logic [2:0] MODE_MAGENTA = 3'd6;
  localparam logic [2:0] MODE_YELLOW  = 3'd7;

  // MSB-first bit replication so full-scale input maps to 0xFF
  function automatic logic [7:0] expand_luma(input logic [IW-1:0] v);
    logic [7:0] y;
    for (int i = 0; i < 8; i++) y[7-i] = v[IW-1-(i%IW)];
    return y;
  endfunction

  logic [7:0]      y_q [PIPE];
  logic [7:0]      y_d [PIPE];
  logic [PIPE-1:0] hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic [2:0]      mode_q, mode_d;
  logic            ce_q;
  logic            vs_rise;

`ifdef VIDOUT_SCANLINE_EN
  logic [PIPE-1:0] par_q, par_d;
  logic            line_par_q, line_par_d;
  logic            hs_rise;
`else
  logic            unused_sl_en;
  assign unused_sl_en = sl_en;
`endif

  always_comb begin
    y_d     = y_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    de_d    = de_q;
    vs_rise = ce_pix & vs_in & ~vs_q[0];
    mode_d  = vs_rise ? mode_in : mode_q;
`ifdef VIDOUT_SCANLINE_EN
    par_d      = par_q;
    hs_rise    = ce_pix & hs_in & ~hs_q[0];
    line_par_d = line_par_q;
    if (vs_rise)      line_par_d = 1'b0;
    else if (hs_rise) line_par_d = ~line_par_q;
`endif
    if (ce_pix) begin
      for (int i = PIPE-1; i > 0; i--) begin
        y_d[i]  = y_q[i-1];
        hs_d[i] = hs_q[i-1];
        vs_d[i] = vs_q[i-1];
        de_d[i] = de_q[i-1];
`ifdef VIDOUT_SCANLINE_EN
        par_d[i] = par_q[i-1];
`endif
      end
      y_d[0]  = expand_luma(video_in);
      hs_d[0] = hs_in;
      vs_d[0] = vs_in;
      de_d[0] = ~(hb_in | vb_in);
`ifdef VIDOUT_SCANLINE_EN
      // pixel carries the parity of the line it belongs to, including the hs edge cycle
      par_d[0] = line_par_d;
`endif
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PIPE; i++) y_q[i] <= '0;
      hs_q   <= '0;
      vs_q   <= '0;
      de_q   <= '0;
      mode_q <= '0;
      ce_q   <= 1'b0;
`ifdef VIDOUT_SCANLINE_EN
      par_q      <= '0;
      line_par_q <= 1'b0;
`endif
    end else begin
      y_q    <= y_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      de_q   <= de_d;
      mode_q <= mode_d;
      ce_q   <= ce_pix;
`ifdef VIDOUT_SCANLINE_EN
      par_q      <= par_d;
      line_par_q <= line_par_d;
`endif
    end
  end

  logic [7:0] y_o, a_o, r_t, g_t, b_t;

  always_comb begin
    y_o = y_q[PIPE-1];
    a_o = y_o - {2'b00, y_o[7:2]};
    r_t = '0;
    g_t = '0;
    b_t = '0;
    case (mode_q)
      MODE_WHITE:   begin r_t = y_o; g_t = y_o; b_t = y_o; end
      MODE_RED:     r_t = y_o;
      MODE_GREEN:   g_t = y_o;
      MODE_BLUE:    b_t = y_o;
      MODE_AMBER:   begin r_t = y_o; g_t = a_o; end
      MODE_CYAN:    begin g_t = y_o; b_t = y_o; end
      MODE_MAGENTA: begin r_t = y_o; b_t = y_o; end
      MODE_YELLOW:  begin r_t = y_o; g_t = y_o; end
      default:      ;
    endcase
`ifdef VIDOUT_SCANLINE_EN
    if (sl_en && par_q[PIPE-1]) begin
      r_t = {1'b0, r_t[7:1]};
      g_t = {1'b0, g_t[7:1]};
      b_t = {1'b0, b_t[7:1]};
    end
`endif
    r_out = de_q[PIPE-1] ? r_t : 8'h00;
    g_out = de_q[PIPE-1] ? g_t : 8'h00;
    b_out = de_q[PIPE-1] ? b_t : 8'h00;
  end

  assign hs_out = hs_q[PIPE-1];
  assign vs_out = vs_q[PIPE-1];
  assign de_out = de_q[PIPE-1];
  assign ce_out = ce_q;

endmodule
